// File: rtl/mem_req_ctrl.sv
// Load/store request controller between the execute stage and the D-cache.
// Latency: load wb_valid two cycles after accept at best; misaligned ops one cycle. Backpressure: stall while a cache op is outstanding.
module mem_req_ctrl (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_width,
  input  logic        req_sign,
  input  logic [4:0]  req_rd,
  input  logic [31:0] req_wdata,
  input  logic        flush,
  output logic        cache_valid,
  output logic        cache_op,
  output logic [31:0] cache_addr,
  output logic [3:0]  cache_wtype,
  output logic [31:0] cache_wdata,
  input  logic        cache_data_valid,
  input  logic [31:0] cache_rdata,
  input  logic [6:0]  cache_exception,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [6:0]  wb_exp,
  output logic [31:0] wb_badv,
  output logic        stall
);

  localparam logic [6:0] EXC_ALE = 7'h09;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t      state_q, state_d;
  logic        cancel_q, cancel_d;

  logic        r_write;
  logic [31:0] r_addr;
  logic [1:0]  r_width;
  logic        r_sign;
  logic [4:0]  r_rd;
  logic [31:0] r_wdata;

  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_d;
  logic [31:0] wb_data_d;
  logic [6:0]  wb_exp_d;
  logic [31:0] wb_badv_d;

  logic        accept;
  logic        misaligned;
  logic        complete;
  logic        mis_done;
  logic [31:0] rdata_sh;
  logic [31:0] load_val;

  always_comb begin
    misaligned = 1'b0;
    case (req_width)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr[0];
      default: misaligned = |req_addr[1:0];
    endcase
  end

  // Next state; a flush seen in WAIT cancels the result but the cache op still runs to completion.
  always_comb begin
    state_d  = state_q;
    cancel_d = cancel_q;
    accept   = 1'b0;
    complete = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (flush) cancel_d = 1'b1;
        if (cache_data_valid) begin
          cancel_d = 1'b0;
          if (cancel_q || flush) begin
            state_d = ST_IDLE;
          end else begin
            state_d  = ST_DONE;
            complete = 1'b1;
          end
        end
      end
      default: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (req_valid) begin
          accept  = 1'b1;
          state_d = misaligned ? ST_DONE : ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  assign mis_done = accept & misaligned;

  always_comb begin
    rdata_sh = cache_rdata >> {r_addr[1:0], 3'b000};
    load_val = rdata_sh;
    case (r_width)
      2'b00:   load_val = {{24{r_sign & rdata_sh[7]}}, rdata_sh[7:0]};
      2'b01:   load_val = {{16{r_sign & rdata_sh[15]}}, rdata_sh[15:0]};
      default: load_val = rdata_sh;
    endcase
  end

  always_comb begin
    wb_valid_d = complete | mis_done;
    wb_rd_d    = '0;
    wb_data_d  = '0;
    wb_exp_d   = '0;
    wb_badv_d  = '0;
    if (complete) begin
      if (cache_exception != 7'd0) begin
        wb_exp_d  = cache_exception;
        wb_badv_d = r_addr;
      end else if (!r_write) begin
        wb_rd_d   = r_rd;
        wb_data_d = load_val;
      end
    end else if (mis_done) begin
      wb_exp_d  = EXC_ALE;
      wb_badv_d = req_addr;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      cancel_q   <= 1'b0;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_width    <= '0;
      r_sign     <= 1'b0;
      r_rd       <= '0;
      r_wdata    <= '0;
      wb_valid_q <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      wb_exp     <= '0;
      wb_badv    <= '0;
    end else begin
      state_q    <= state_d;
      cancel_q   <= cancel_d;
      wb_valid_q <= wb_valid_d;
      wb_rd      <= wb_rd_d;
      wb_data    <= wb_data_d;
      wb_exp     <= wb_exp_d;
      wb_badv    <= wb_badv_d;
      if (accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_width <= req_width;
        r_sign  <= req_sign;
        r_rd    <= req_rd;
        r_wdata <= req_wdata;
      end
    end
  end

  // A flush arriving in the DONE cycle must still kill the pulse already registered.
  assign wb_valid = wb_valid_q & ~flush;
  assign stall    = (state_q == ST_WAIT);

  assign cache_valid = (state_q == ST_WAIT);
  assign cache_op    = r_write;
  assign cache_addr  = r_addr;

  always_comb begin
    cache_wtype = 4'b0000;
    cache_wdata = r_wdata;
    case (r_width)
      2'b00: begin
        cache_wtype = 4'b0001 << r_addr[1:0];
        cache_wdata = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        cache_wtype = 4'b0011 << r_addr[1:0];
        cache_wdata = {2{r_wdata[15:0]}};
      end
      default: begin
        cache_wtype = 4'b1111;
        cache_wdata = r_wdata;
      end
    endcase
    if (!r_write) cache_wtype = 4'b0000;
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl: inputs change and outputs are checked on the falling edge.
module tb_mem_req_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_write, req_sign, flush;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_width;
  logic [4:0]  req_rd;
  logic        cache_valid, cache_op;
  logic [31:0] cache_addr, cache_wdata;
  logic [3:0]  cache_wtype;
  logic        cache_data_valid;
  logic [31:0] cache_rdata;
  logic [6:0]  cache_exception;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, wb_badv;
  logic [6:0]  wb_exp;
  logic        stall;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_req_ctrl dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_width(req_width), .req_sign(req_sign), .req_rd(req_rd),
    .req_wdata(req_wdata), .flush(flush),
    .cache_valid(cache_valid), .cache_op(cache_op), .cache_addr(cache_addr),
    .cache_wtype(cache_wtype), .cache_wdata(cache_wdata),
    .cache_data_valid(cache_data_valid), .cache_rdata(cache_rdata),
    .cache_exception(cache_exception),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_exp(wb_exp),
    .wb_badv(wb_badv), .stall(stall)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [1:0] wd,
                       input logic s, input logic [4:0] rd, input logic [31:0] wdat);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_width = wd;
    req_sign  = s;
    req_rd    = rd;
    req_wdata = wdat;
  endtask

  initial begin
    rstn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_width = '0;
    req_sign = 1'b0; req_rd = '0; req_wdata = '0; flush = 1'b0;
    cache_data_valid = 1'b0; cache_rdata = '0; cache_exception = '0;

    @(negedge clk); @(negedge clk);
    chk("rst_cache_valid", 32'(cache_valid), 32'd0);
    chk("rst_wb_valid",    32'(wb_valid),    32'd0);
    chk("rst_stall",       32'(stall),       32'd0);
    chk("rst_cache_addr",  cache_addr,       32'd0);
    chk("rst_wb_badv",     wb_badv,          32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // signed byte load, one-cycle cache response
    issue(1'b0, 32'h0000_1003, 2'b00, 1'b1, 5'd5, 32'd0);
    @(negedge clk);
    chk("lb_stall",       32'(stall),       32'd1);
    chk("lb_cache_valid", 32'(cache_valid), 32'd1);
    chk("lb_cache_addr",  cache_addr,       32'h0000_1003);
    chk("lb_cache_op",    32'(cache_op),    32'd0);
    chk("lb_wtype",       32'(cache_wtype), 32'd0);
    req_valid = 1'b0; cache_data_valid = 1'b1; cache_rdata = 32'h80FF_FF00;
    @(negedge clk);
    chk("lb_wb_valid", 32'(wb_valid),    32'd1);
    chk("lb_wb_data",  wb_data,          32'hFFFF_FF80);
    chk("lb_wb_rd",    32'(wb_rd),       32'd5);
    chk("lb_wb_exp",   32'(wb_exp),      32'd0);
    chk("lb_stall2",   32'(stall),       32'd0);
    cache_data_valid = 1'b0;
    @(negedge clk);
    chk("lb_wb_once", 32'(wb_valid), 32'd0);

    // half store to upper lanes
    issue(1'b1, 32'h0000_2002, 2'b01, 1'b0, 5'd7, 32'h0000_ABCD);
    @(negedge clk);
    chk("sh_wtype",    32'(cache_wtype), 32'h0000_000C);
    chk("sh_wdata",    cache_wdata,      32'hABCD_ABCD);
    chk("sh_cache_op", 32'(cache_op),    32'd1);
    req_valid = 1'b0; cache_data_valid = 1'b1;
    @(negedge clk);
    chk("sh_wb_valid", 32'(wb_valid), 32'd1);
    chk("sh_wb_rd",    32'(wb_rd),    32'd0);
    chk("sh_wb_data",  wb_data,       32'd0);
    cache_data_valid = 1'b0;
    @(negedge clk);

    // misaligned word load
    issue(1'b0, 32'h0000_3001, 2'b10, 1'b0, 5'd6, 32'd0);
    @(negedge clk);
    chk("ale_cache_valid", 32'(cache_valid), 32'd0);
    chk("ale_wb_valid",    32'(wb_valid),    32'd1);
    chk("ale_wb_exp",      32'(wb_exp),      32'h09);
    chk("ale_wb_badv",     wb_badv,          32'h0000_3001);
    chk("ale_wb_rd",       32'(wb_rd),       32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    chk("ale_wb_once", 32'(wb_valid), 32'd0);

    // word load with cache response delayed five cycles
    issue(1'b0, 32'h0000_4000, 2'b10, 1'b0, 5'd9, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("dly_cache_valid", 32'(cache_valid), 32'd1);
      chk("dly_stall",       32'(stall),       32'd1);
      chk("dly_cache_addr",  cache_addr,       32'h0000_4000);
      chk("dly_wb_valid",    32'(wb_valid),    32'd0);
      req_valid = 1'b0;
      if (i == 5) begin
        cache_data_valid = 1'b1; cache_rdata = 32'h1234_5678;
      end
    end
    @(negedge clk);
    chk("dly_wb_valid_done", 32'(wb_valid), 32'd1);
    chk("dly_wb_data",       wb_data,       32'h1234_5678);
    chk("dly_wb_rd",         32'(wb_rd),    32'd9);
    cache_data_valid = 1'b0;
    @(negedge clk);
    chk("dly_wb_once", 32'(wb_valid), 32'd0);

    // cache exception, then misaligned store accepted in the DONE cycle
    issue(1'b0, 32'h0000_5002, 2'b01, 1'b0, 5'd10, 32'd0);
    @(negedge clk);
    req_valid = 1'b0; cache_data_valid = 1'b1; cache_exception = 7'h0F; cache_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("exc_wb_valid", 32'(wb_valid), 32'd1);
    chk("exc_wb_exp",   32'(wb_exp),   32'h0F);
    chk("exc_wb_badv",  wb_badv,       32'h0000_5002);
    chk("exc_wb_rd",    32'(wb_rd),    32'd0);
    chk("exc_wb_data",  wb_data,       32'd0);
    cache_data_valid = 1'b0; cache_exception = 7'h00;
    issue(1'b1, 32'h0000_9002, 2'b10, 1'b0, 5'd0, 32'h1111_2222);
    @(negedge clk);
    chk("b2b_wb_valid", 32'(wb_valid), 32'd1);
    chk("b2b_wb_exp",   32'(wb_exp),   32'h09);
    chk("b2b_wb_badv",  wb_badv,       32'h0000_9002);
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_wb_once", 32'(wb_valid), 32'd0);

    // flush during WAIT, then a normal unsigned byte load
    issue(1'b0, 32'h0000_6000, 2'b10, 1'b0, 5'd3, 32'd0);
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_stall",       32'(stall),       32'd1);
    chk("fl_cache_valid", 32'(cache_valid), 32'd1);
    @(negedge clk);
    chk("fl_cache_valid2", 32'(cache_valid), 32'd1);
    cache_data_valid = 1'b1;
    @(negedge clk);
    chk("fl_no_wb",   32'(wb_valid), 32'd0);
    chk("fl_stall_0", 32'(stall),    32'd0);
    cache_data_valid = 1'b0;
    issue(1'b0, 32'h0000_7001, 2'b00, 1'b0, 5'd4, 32'd0);
    @(negedge clk);
    chk("lbu_cache_addr", cache_addr, 32'h0000_7001);
    req_valid = 1'b0; cache_data_valid = 1'b1; cache_rdata = 32'h0000_AB00;
    @(negedge clk);
    chk("lbu_wb_valid", 32'(wb_valid), 32'd1);
    chk("lbu_wb_data",  wb_data,       32'h0000_00AB);
    chk("lbu_wb_rd",    32'(wb_rd),    32'd4);
    cache_data_valid = 1'b0;
    @(negedge clk);

    // signed half load from upper half
    issue(1'b0, 32'h0000_8002, 2'b01, 1'b1, 5'd11, 32'd0);
    @(negedge clk);
    req_valid = 1'b0; cache_data_valid = 1'b1; cache_rdata = 32'h8001_0000;
    @(negedge clk);
    chk("lh_wb_data", wb_data,    32'hFFFF_8001);
    chk("lh_wb_rd",   32'(wb_rd), 32'd11);
    cache_data_valid = 1'b0;
    @(negedge clk);

    // flush in the DONE cycle kills the pulse and blocks a new accept
    issue(1'b0, 32'h0000_A000, 2'b10, 1'b0, 5'd12, 32'd0);
    @(negedge clk);
    req_valid = 1'b0; cache_data_valid = 1'b1; cache_rdata = 32'h0000_0001;
    @(negedge clk);
    cache_data_valid = 1'b0; flush = 1'b1;
    issue(1'b0, 32'h0000_A100, 2'b10, 1'b0, 5'd13, 32'd0);
    #1;
    chk("fdone_wb_valid", 32'(wb_valid), 32'd0);
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    chk("fdone_no_accept", 32'(cache_valid), 32'd0);
    chk("fdone_wb_valid2", 32'(wb_valid),    32'd0);
    @(negedge clk);

    // reset asserted during WAIT, late response ignored
    issue(1'b0, 32'h0000_B000, 2'b10, 1'b0, 5'd13, 32'd0);
    @(negedge clk);
    chk("rw_cache_valid", 32'(cache_valid), 32'd1);
    req_valid = 1'b0; rstn = 1'b0;
    #1;
    chk("rw_cache_valid0", 32'(cache_valid), 32'd0);
    chk("rw_stall0",       32'(stall),       32'd0);
    chk("rw_cache_addr0",  cache_addr,       32'd0);
    @(negedge clk);
    rstn = 1'b1; cache_data_valid = 1'b1;
    @(negedge clk);
    chk("rw_late_wb",    32'(wb_valid),    32'd0);
    chk("rw_late_stall", 32'(stall),       32'd0);
    chk("rw_late_cv",    32'(cache_valid), 32'd0);
    cache_data_valid = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
